sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 8: words per SDRAM burst, power of two.
REQ-002 Parameter FIFO_DEPTH, default 512: depth in words of both the read and write FIFOs.
REQ-003 Parameter RD_LOW_WM, default 64: read FIFO level at or below which a read is urgent.
REQ-004 Parameter WR_HIGH_WM, default 256: write FIFO level at or above which a write is urgent.
REQ-005 Parameter FRAME_WORDS, default 384000: words read per LCD frame (800x480).
REQ-006 Parameter WR_WRAP, default 8388608: write address wrap point in words, a multiple of BURST_LEN.
REQ-007 The ports SHALL be (name, direction, width, meaning):
- iCLK  in  1  system clock (50 MHz); one clock; reset is asynchronous and active-low.
- iRSTN  in  1  asynchronous active-low reset.
- iWr_Level  in  10  write FIFO fill level (SPI pixel side).
- iWr_Addr_Clr  in  1  pulse; rewind the write pointer to 0 (new image set).
- iRd_Level  in  10  read FIFO fill level (MTL side).
- iNew_Frame  in  1  pulse; start a frame read.
- iRd_Base  in  23  frame base word address, sampled with iNew_Frame.
- oCmd_Valid  out  1  burst command valid.
- iCmd_Ready  in  1  SDRAM controller accepts the command.
- oCmd_Write  out  1  1 = write burst, 0 = read burst.
- oCmd_Addr  out  23  burst start word address.
- iBurst_Done  in  1  pulse; the accepted burst is finished.
- oWr_Grant / oRd_Grant  out  1 each  high from command accept until iBurst_Done.
- oFrame_Done  out  1  one-cycle pulse when the last frame burst completes.

Function
REQ-008 FSM states SHALL be IDLE, CMD (oCmd_Valid high) and BUSY (waiting for iBurst_Done).
REQ-009 IDLE SHALL evaluate eligibility each cycle and enter CMD the next cycle when any requester is eligible.
REQ-010 Read eligible: rd_active and FIFO_DEPTH - iRd_Level >= BURST_LEN.
REQ-011 Write eligible: iWr_Level >= BURST_LEN.
REQ-012 Priority SHALL be: urgent read (eligible and iRd_Level <= RD_LOW_WM) > urgent write (eligible and iWr_Level >= WR_HIGH_WM) > round-robin among the eligible requesters, favouring the one not granted last.
REQ-013 Round-robin state SHALL be set to the requester of each accepted command, and reset to "write last".
REQ-014 In CMD, oCmd_Valid, oCmd_Write and oCmd_Addr SHALL stay stable until the iCmd_Ready handshake; acceptance SHALL move to BUSY and assert the matching grant.
REQ-015 BUSY SHALL return to IDLE on iBurst_Done and deassert the grant in that cycle; minimum turnaround is one IDLE cycle.
REQ-016 Write pointer SHALL advance by BURST_LEN at each accepted write and wrap to 0 when reaching WR_WRAP.
REQ-017 Read pointer SHALL advance by BURST_LEN at each accepted read; rd_remaining (19 bit) SHALL decrement by BURST_LEN.
REQ-018 Reaching rd_remaining = 0 SHALL clear rd_active.
REQ-019 oFrame_Done SHALL pulse on iBurst_Done of the read burst that brought rd_remaining to 0.
REQ-020 iNew_Frame SHALL set a pending flag and latch iRd_Base.
REQ-021 The pending reload (read pointer = base, rd_remaining = FRAME_WORDS, rd_active = 1) SHALL apply only in IDLE, never to an in-flight command.
REQ-022 iWr_Addr_Clr SHALL be handled the same way through its own pending flag.
REQ-023 A new iNew_Frame while a reload is pending SHALL overwrite the latched base; the last pulse wins.
REQ-024 A reload applied in IDLE SHALL take effect before arbitration in that same cycle.
REQ-025 iBurst_Done outside BUSY and iCmd_Ready outside CMD SHALL be ignored.
REQ-026 FRAME_WORDS not a multiple of BURST_LEN is unsupported; rd_remaining SHALL saturate at 0.

Reset
REQ-027 On iRSTN low, the block SHALL asynchronously enter IDLE with all outputs 0.
REQ-028 Reset SHALL clear both pointers, rd_remaining, rd_active, both pending flags and the round-robin state to "write last".
REQ-029 Reset mid-burst SHALL abandon the burst; no grant or oFrame_Done follows release.

Verification
REQ-030 Reset release, then iNew_Frame with iRd_Base=0x1000, iRd_Level=0 -> read command at addr 0x1000, then 0x1008.
REQ-031 With no frame active, iWr_Level=8 -> one write at addr 0.
REQ-032 With no frame active, iWr_Level=300 -> repeated writes at 0, 8, 16.
REQ-033 iRd_Level=100 and iWr_Level=20, both eligible -> grants alternate R,W,R,W.
REQ-034 Set iRd_Level=40 -> read wins over iWr_Level=300.
REQ-035 Set iRd_Level=100 -> write wins over the read.
REQ-036 FRAME_WORDS=16 override, iRd_Level held 0 -> exactly 2 reads, oFrame_Done pulses once on the 2nd iBurst_Done, then writes only.
REQ-037 iNew_Frame with base 0x2000 during BUSY of a read at 0x1000 -> that burst completes unchanged, next read at 0x2000.
REQ-038 Write pointer at WR_WRAP-8 -> write at WR_WRAP-8, next at 0.
REQ-039 iRSTN low while iCmd_Ready is held low in CMD -> oCmd_Valid drops immediately, next command after release starts at addr 0.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Arbitrates SDRAM burst commands between the LCD frame reader and the SPI pixel writer.
// State | meaning
//   IDLE | apply pending reloads, pick a requester for the next burst
//   CMD  | command presented, waiting for iCmd_Ready
//   BUSY | burst accepted, waiting for iBurst_Done
module sdram_arbiter #(
   parameter int unsigned BURST_LEN   = 8,
   parameter int unsigned FIFO_DEPTH  = 512,
   parameter int unsigned RD_LOW_WM   = 64,
   parameter int unsigned WR_HIGH_WM  = 256,
   parameter int unsigned FRAME_WORDS = 384000,
   parameter int unsigned WR_WRAP     = 8388608
) (
   input  logic        iCLK,
   input  logic        iRSTN,
   input  logic [9:0]  iWr_Level,
   input  logic        iWr_Addr_Clr,
   input  logic [9:0]  iRd_Level,
   input  logic        iNew_Frame,
   input  logic [22:0] iRd_Base,
   output logic        oCmd_Valid,
   input  logic        iCmd_Ready,
   output logic        oCmd_Write,
   output logic [22:0] oCmd_Addr,
   input  logic        iBurst_Done,
   output logic        oWr_Grant,
   output logic        oRd_Grant,
   output logic        oFrame_Done
);

   typedef enum logic [1:0] {IDLE, CMD, BUSY} state_t;

   state_t      state_q, state_d;
   logic [22:0] wr_ptr_q, wr_ptr_d;
   logic [22:0] rd_ptr_q, rd_ptr_d;
   logic [22:0] base_q, base_d;
   logic [22:0] cmd_addr_q, cmd_addr_d;
   logic [18:0] rd_rem_q, rd_rem_d;
   logic        rd_active_q, rd_active_d;
   logic        frame_pend_q, frame_pend_d;
   logic        clr_pend_q, clr_pend_d;
   logic        rr_rd_last_q, rr_rd_last_d;
   logic        cmd_write_q, cmd_write_d;
   logic        last_rd_q, last_rd_d;

   logic        rd_elig, wr_elig, rd_urg, wr_urg, pick_wr;
   logic [23:0] wr_next;
   logic [18:0] rd_rem_next;

   always_ff @(posedge iCLK or negedge iRSTN) begin
      if (!iRSTN) begin
         state_q      <= IDLE;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         base_q       <= '0;
         cmd_addr_q   <= '0;
         rd_rem_q     <= '0;
         rd_active_q  <= 1'b0;
         frame_pend_q <= 1'b0;
         clr_pend_q   <= 1'b0;
         rr_rd_last_q <= 1'b0;
         cmd_write_q  <= 1'b0;
         last_rd_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         base_q       <= base_d;
         cmd_addr_q   <= cmd_addr_d;
         rd_rem_q     <= rd_rem_d;
         rd_active_q  <= rd_active_d;
         frame_pend_q <= frame_pend_d;
         clr_pend_q   <= clr_pend_d;
         rr_rd_last_q <= rr_rd_last_d;
         cmd_write_q  <= cmd_write_d;
         last_rd_q    <= last_rd_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      base_d       = base_q;
      cmd_addr_d   = cmd_addr_q;
      rd_rem_d     = rd_rem_q;
      rd_active_d  = rd_active_q;
      frame_pend_d = frame_pend_q;
      clr_pend_d   = clr_pend_q;
      rr_rd_last_d = rr_rd_last_q;
      cmd_write_d  = cmd_write_q;
      last_rd_d    = last_rd_q;
      rd_elig      = 1'b0;
      wr_elig      = 1'b0;
      rd_urg       = 1'b0;
      wr_urg       = 1'b0;
      pick_wr      = 1'b0;
      wr_next      = {1'b0, wr_ptr_q} + 24'(BURST_LEN);
      rd_rem_next  = (rd_rem_q > 19'(BURST_LEN)) ? (rd_rem_q - 19'(BURST_LEN)) : '0;

      case (state_q)
         IDLE: begin
            // Reloads land here so arbitration below already sees the new pointers.
            if (clr_pend_q) begin
               wr_ptr_d   = '0;
               clr_pend_d = 1'b0;
            end
            if (frame_pend_q) begin
               rd_ptr_d     = base_q;
               rd_rem_d     = 19'(FRAME_WORDS);
               rd_active_d  = 1'b1;
               frame_pend_d = 1'b0;
            end
            rd_elig = rd_active_d && (({22'd0, iRd_Level} + BURST_LEN) <= FIFO_DEPTH);
            wr_elig = {22'd0, iWr_Level} >= BURST_LEN;
            rd_urg  = rd_elig && ({22'd0, iRd_Level} <= RD_LOW_WM);
            wr_urg  = wr_elig && ({22'd0, iWr_Level} >= WR_HIGH_WM);
            if (rd_urg)                  pick_wr = 1'b0;
            else if (wr_urg)             pick_wr = 1'b1;
            else if (rd_elig && wr_elig) pick_wr = rr_rd_last_q;
            else                         pick_wr = wr_elig;
            if (rd_elig || wr_elig) begin
               state_d     = CMD;
               cmd_write_d = pick_wr;
               cmd_addr_d  = pick_wr ? wr_ptr_d : rd_ptr_d;
            end
         end
         CMD: begin
            if (iCmd_Ready) begin
               state_d      = BUSY;
               rr_rd_last_d = !cmd_write_q;
               if (cmd_write_q) begin
                  wr_ptr_d  = (wr_next >= 24'(WR_WRAP)) ? '0 : wr_next[22:0];
                  last_rd_d = 1'b0;
               end else begin
                  rd_ptr_d  = rd_ptr_q + 23'(BURST_LEN);
                  rd_rem_d  = rd_rem_next;
                  last_rd_d = (rd_rem_next == '0);
                  if (rd_rem_next == '0) rd_active_d = 1'b0;
               end
            end
         end
         BUSY: begin
            if (iBurst_Done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // A pulse in the same cycle as a reload stays pending; the last pulse's base wins.
      if (iNew_Frame) begin
         frame_pend_d = 1'b1;
         base_d       = iRd_Base;
      end
      if (iWr_Addr_Clr) clr_pend_d = 1'b1;
   end

   assign oCmd_Valid  = (state_q == CMD);
   assign oCmd_Write  = (state_q == CMD) && cmd_write_q;
   assign oCmd_Addr   = cmd_addr_q;
   assign oWr_Grant   = (state_q == BUSY) && cmd_write_q;
   assign oRd_Grant   = (state_q == BUSY) && !cmd_write_q;
   assign oFrame_Done = (state_q == BUSY) && iBurst_Done && last_rd_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter with a 16-word frame and a 32-word write wrap.
module tb_sdram_arbiter;

   logic        iCLK = 1'b0;
   logic        iRSTN;
   logic [9:0]  iWr_Level;
   logic        iWr_Addr_Clr;
   logic [9:0]  iRd_Level;
   logic        iNew_Frame;
   logic [22:0] iRd_Base;
   logic        oCmd_Valid;
   logic        iCmd_Ready;
   logic        oCmd_Write;
   logic [22:0] oCmd_Addr;
   logic        iBurst_Done;
   logic        oWr_Grant;
   logic        oRd_Grant;
   logic        oFrame_Done;

   int checks = 0;
   int errors = 0;

   always #5 iCLK = ~iCLK;

   sdram_arbiter #(
      .BURST_LEN(8), .FIFO_DEPTH(512), .RD_LOW_WM(64), .WR_HIGH_WM(256),
      .FRAME_WORDS(16), .WR_WRAP(32)
   ) dut (
      .iCLK(iCLK), .iRSTN(iRSTN), .iWr_Level(iWr_Level), .iWr_Addr_Clr(iWr_Addr_Clr),
      .iRd_Level(iRd_Level), .iNew_Frame(iNew_Frame), .iRd_Base(iRd_Base),
      .oCmd_Valid(oCmd_Valid), .iCmd_Ready(iCmd_Ready), .oCmd_Write(oCmd_Write),
      .oCmd_Addr(oCmd_Addr), .iBurst_Done(iBurst_Done), .oWr_Grant(oWr_Grant),
      .oRd_Grant(oRd_Grant), .oFrame_Done(oFrame_Done)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge iCLK);
      #1;
   endtask

   task automatic expect_idle(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         tick();
         chk({tag, "_novalid"}, 32'(oCmd_Valid), 32'd0);
      end
   endtask

   task automatic wait_cmd(input logic exp_w, input logic [22:0] exp_a, input string tag);
      int n;
      n = 0;
      while (oCmd_Valid !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, 32'(oCmd_Valid), 32'd1);
      chk({tag, "_write"}, 32'(oCmd_Write), 32'(exp_w));
      chk({tag, "_addr"}, 32'(oCmd_Addr), 32'(exp_a));
   endtask

   task automatic burst(input logic exp_w, input logic [22:0] exp_a, input logic exp_fd,
                        input int hold, input logic nf, input logic [22:0] b1,
                        input logic [22:0] b2, input string tag);
      wait_cmd(exp_w, exp_a, tag);
      for (int i = 0; i < hold; i++) begin
         tick();
         chk({tag, "_hold_valid"}, 32'(oCmd_Valid), 32'd1);
         chk({tag, "_hold_addr"}, 32'(oCmd_Addr), 32'(exp_a));
      end
      iCmd_Ready = 1'b1;
      tick();
      iCmd_Ready = 1'b0;
      chk({tag, "_wgrant"}, 32'(oWr_Grant), 32'(exp_w));
      chk({tag, "_rgrant"}, 32'(oRd_Grant), 32'(!exp_w));
      chk({tag, "_validoff"}, 32'(oCmd_Valid), 32'd0);
      if (nf) begin
         iNew_Frame = 1'b1;
         iRd_Base   = b1;
         tick();
         iRd_Base   = b2;
         tick();
         iNew_Frame = 1'b0;
      end else begin
         tick();
      end
      chk({tag, "_grant_held"}, 32'(oWr_Grant | oRd_Grant), 32'd1);
      iBurst_Done = 1'b1;
      #1;
      chk({tag, "_frame_done"}, 32'(oFrame_Done), 32'(exp_fd));
      tick();
      iBurst_Done = 1'b0;
      chk({tag, "_grants_off"}, 32'(oWr_Grant | oRd_Grant), 32'd0);
   endtask

   task automatic new_frame(input logic [22:0] base);
      iNew_Frame = 1'b1;
      iRd_Base   = base;
      tick();
      iNew_Frame = 1'b0;
   endtask

   initial begin
      iRSTN = 1'b0; iWr_Level = '0; iWr_Addr_Clr = 1'b0; iRd_Level = '0;
      iNew_Frame = 1'b0; iRd_Base = '0; iCmd_Ready = 1'b0; iBurst_Done = 1'b0;
      repeat (3) tick();
      chk("rst_valid", 32'(oCmd_Valid), 32'd0);
      chk("rst_write", 32'(oCmd_Write), 32'd0);
      chk("rst_addr", 32'(oCmd_Addr), 32'd0);
      chk("rst_grants", 32'(oWr_Grant | oRd_Grant), 32'd0);
      chk("rst_fdone", 32'(oFrame_Done), 32'd0);
      iRSTN = 1'b1;
      expect_idle(3, "post_rst");

      // Frame read: two bursts, the second ends the frame.
      new_frame(23'h1000);
      burst(1'b0, 23'h1000, 1'b0, 2, 1'b0, '0, '0, "rd0");
      burst(1'b0, 23'h1008, 1'b1, 0, 1'b0, '0, '0, "rd1");
      expect_idle(5, "frame_end");

      // Write eligibility boundary, then a single write.
      iWr_Level = 10'd7;
      expect_idle(3, "wr7");
      iWr_Level = 10'd8;
      burst(1'b1, 23'd0, 1'b0, 0, 1'b0, '0, '0, "wr_single");
      iWr_Level = 10'd0;
      expect_idle(3, "wr_stop");

      // Back-to-back writes wrapping at 32.
      iWr_Level = 10'd300;
      burst(1'b1, 23'd8, 1'b0, 0, 1'b0, '0, '0, "wr_a");
      burst(1'b1, 23'd16, 1'b0, 0, 1'b0, '0, '0, "wr_b");
      burst(1'b1, 23'd24, 1'b0, 0, 1'b0, '0, '0, "wr_wrap_m8");
      burst(1'b1, 23'd0, 1'b0, 0, 1'b0, '0, '0, "wr_wrap_0");
      iWr_Level = 10'd0;

      iWr_Addr_Clr = 1'b1;
      tick();
      iWr_Addr_Clr = 1'b0;
      expect_idle(3, "clr");

      // Round robin R,W,R,W.
      iRd_Level = 10'd100;
      new_frame(23'h3000);
      burst(1'b0, 23'h3000, 1'b0, 0, 1'b0, '0, '0, "rr_r0");
      iWr_Level = 10'd20;
      burst(1'b1, 23'd0, 1'b0, 0, 1'b0, '0, '0, "rr_w0");
      burst(1'b0, 23'h3008, 1'b1, 0, 1'b0, '0, '0, "rr_r1");
      burst(1'b1, 23'd8, 1'b0, 0, 1'b0, '0, '0, "rr_w1");
      iWr_Level = 10'd0;

      // Urgency: read not eligible at 505, urgent write beats rr, urgent read beats everything.
      iRd_Level = 10'd505;
      new_frame(23'h4000);
      expect_idle(3, "rd505");
      iRd_Level = 10'd100;
      iWr_Level = 10'd300;
      burst(1'b1, 23'd16, 1'b0, 0, 1'b0, '0, '0, "urg_w");
      iRd_Level = 10'd40;
      burst(1'b0, 23'h4000, 1'b0, 0, 1'b0, '0, '0, "urg_r0");
      burst(1'b0, 23'h4008, 1'b1, 0, 1'b0, '0, '0, "urg_r1");
      burst(1'b1, 23'd24, 1'b0, 0, 1'b0, '0, '0, "post_w0");
      burst(1'b1, 23'd0, 1'b0, 0, 1'b0, '0, '0, "post_w1");
      iWr_Level = 10'd0;

      // New frame arriving mid-burst: two pulses, the last base wins.
      iRd_Level = 10'd100;
      new_frame(23'h1000);
      burst(1'b0, 23'h1000, 1'b0, 0, 1'b1, 23'h2800, 23'h2000, "mid_r");
      burst(1'b0, 23'h2000, 1'b0, 0, 1'b0, '0, '0, "reload_r0");
      burst(1'b0, 23'h2008, 1'b1, 0, 1'b0, '0, '0, "reload_r1");
      expect_idle(3, "reload_end");

      // Reset while a command waits for ready.
      iWr_Level = 10'd300;
      wait_cmd(1'b1, 23'd8, "pre_rst");
      iRSTN = 1'b0;
      #1;
      chk("rst_mid_valid", 32'(oCmd_Valid), 32'd0);
      chk("rst_mid_addr", 32'(oCmd_Addr), 32'd0);
      chk("rst_mid_grants", 32'(oWr_Grant | oRd_Grant), 32'd0);
      tick();
      iRSTN = 1'b1;
      burst(1'b1, 23'd0, 1'b0, 0, 1'b0, '0, '0, "after_rst");
      iWr_Level = 10'd0;
      expect_idle(2, "final");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
